spell_mem_initiator: RTL

- Bus master for the spell memory-mapped peripheral bus: turns single core load/store requests into select/addr/write/data bus cycles and returns read data.
- Sits between the execution core and the peripheral responders (mem IO port block and siblings).
- Guarantees a select-low gap between transactions, so responders' data_ready drops and edge-detected writes (PIN toggle) fire once per request.
- Times out if no responder answers.

---
 rtl/spell_mem_initiator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spell_mem_initiator.sv
// Bus master for the spell peripheral bus: turns single core load/store requests into
// select/addr/write/data bus cycles and returns the read data. Every transaction is
// followed by a select-low recovery cycle so responders see a fresh select edge per request.
module spell_mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    output logic       resp_error,
    output logic       select,
    output logic [7:0] addr,
    output logic       write,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    input  logic       data_ready
);

    typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

    // A zero timeout disables the counter compare entirely.
    localparam bit         TimeoutEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic       select_q, select_d;
    logic       write_q, write_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_error_q, resp_error_d;
    logic [7:0] resp_rdata_q, resp_rdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_hit;

    assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

    // State and registered outputs; reset aborts any transaction without a response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            select_q     <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 8'h00;
            data_out_q   <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 8'h00;
            cnt_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_out_q   <= data_out_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = StAccess;
            end
            StAccess: begin
                if (data_ready || timeout_hit) state_d = StRecover;
            end
            StRecover: begin
                // Leave once the responder drops its ack, or give up on a stuck ack.
                if (!data_ready || timeout_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered bus/response outputs and the timeout counter.
    always_comb begin
        select_d     = select_q;
        write_d      = write_q;
        addr_d       = addr_q;
        data_out_d   = data_out_q;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    data_out_d = req_wdata;
                    write_d    = req_write;
                    select_d   = 1'b1;
                    cnt_d      = 8'h00;
                end
            end
            StAccess: begin
                if (data_ready) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? 8'h00 : data_in;
                    resp_error_d = 1'b0;
                    select_d     = 1'b0;
                    write_d      = 1'b0;
                    cnt_d        = 8'h00;
                end else if (timeout_hit) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 8'h00;
                    resp_error_d = 1'b1;
                    select_d     = 1'b0;
                    write_d      = 1'b0;
                    cnt_d        = 8'h00;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRecover: begin
                if (data_ready) begin
                    cnt_d = timeout_hit ? 8'h00 : cnt_q + 8'd1;
                end
            end
            default: begin
                select_d = 1'b0;
                write_d  = 1'b0;
            end
        endcase
    end

    assign req_ready  = (state_q == StIdle);
    assign select     = select_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_out   = data_out_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;

endmodule
